// File: rtl/clock_pkg.sv
// Shared clock-domain definitions: time constants, BCD digit type and the
// formatter FSM state encoding.
package clock_pkg;

    localparam logic [15:0] SEC_PER_HOUR = 16'd3600;
    localparam logic [15:0] SEC_PER_MIN  = 16'd60;
    localparam logic [15:0] SEC_PER_TEN  = 16'd10;

    typedef logic [3:0] bcd_digit_t;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        HOURS   = 3'd1,
        MINUTES = 3'd2,
        TENS    = 3'd3,
        DONE    = 3'd4
    } hms_state_t;

endpackage

// File: rtl/bcd_incrementer.sv
// Combinational multi-digit BCD +1 with digit-wise carry, an optional wrap
// value (next value becomes zero) and saturation at all nines.
module bcd_incrementer
    import clock_pkg::*;
#(
    parameter int                DIGITS   = 2,
    parameter bit                WRAP_EN  = 1'b0,
    parameter logic [4*DIGITS-1:0] WRAP_MAX = '0
) (
    input  logic [4*DIGITS-1:0] value_i,
    output logic [4*DIGITS-1:0] next_o,
    output logic                saturated_o
);

    logic [4*DIGITS-1:0] sum_s;
    logic                carry_s;
    bcd_digit_t          dig_s;

    // Ripple the +1 through the digits; carry out of the top means all nines.
    always_comb begin
        sum_s   = value_i;
        carry_s = 1'b1;
        dig_s   = 4'd0;
        for (int i = 0; i < DIGITS; i++) begin
            dig_s = value_i[4*i +: 4];
            if (carry_s) begin
                if (dig_s == 4'd9) begin
                    sum_s[4*i +: 4] = 4'd0;
                    carry_s         = 1'b1;
                end else begin
                    sum_s[4*i +: 4] = dig_s + 4'd1;
                    carry_s         = 1'b0;
                end
            end else begin
                sum_s[4*i +: 4] = dig_s;
            end
        end
    end

    // Wrap takes priority; otherwise an all-nines input holds and flags.
    always_comb begin
        next_o      = sum_s;
        saturated_o = 1'b0;
        if (WRAP_EN && (value_i == WRAP_MAX)) begin
            next_o      = '0;
            saturated_o = 1'b0;
        end else if (carry_s) begin
            next_o      = value_i;
            saturated_o = 1'b1;
        end else begin
            next_o      = sum_s;
            saturated_o = 1'b0;
        end
    end

endmodule

// File: rtl/hms_bcd_formatter.sv
// Binary seconds to BCD hh:mm:ss by repeated subtraction, start/busy/done handshake.
// Build option HMS_MOD24_EN: hours wrap 23->00 (time of day), overflow never set.
module hms_bcd_formatter
    import clock_pkg::*;
#(
    parameter int N           = 19,
    parameter int HOUR_DIGITS = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N-1:0]             value,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic                     valid,
    output logic [4*HOUR_DIGITS-1:0] hours_bcd,
    output logic [7:0]               min_bcd,
    output logic [7:0]               sec_bcd,
    output logic                     overflow
);

    localparam int HW = 4*HOUR_DIGITS;
    localparam logic [N-1:0] HOUR_N = N'(SEC_PER_HOUR);
    localparam logic [N-1:0] MIN_N  = N'(SEC_PER_MIN);
    localparam logic [N-1:0] TEN_N  = N'(SEC_PER_TEN);
`ifdef HMS_MOD24_EN
    localparam bit HRS_WRAP_EN = 1'b1;
`else
    localparam bit HRS_WRAP_EN = 1'b0;
`endif
    localparam logic [HW-1:0] HRS_WRAP_MAX = HW'(8'h23);

    hms_state_t    state_q, state_d;
    logic [N-1:0]  rem_q, rem_d;
    logic [HW-1:0] hrs_w_q, hrs_w_d;
    logic [7:0]    min_w_q, min_w_d;
    logic [7:0]    sec_w_q, sec_w_d;
    logic          ovf_w_q, ovf_w_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          valid_q, valid_d;
    logic [HW-1:0] hours_q, hours_d;
    logic [7:0]    min_q, min_d;
    logic [7:0]    sec_q, sec_d;
    logic          ovf_q, ovf_d;

    logic [HW-1:0] hrs_inc_s;
    logic          hrs_sat_s;
    logic [7:0]    min_inc_s;
    logic          min_sat_s;

    bcd_incrementer #(
        .DIGITS   (HOUR_DIGITS),
        .WRAP_EN  (HRS_WRAP_EN),
        .WRAP_MAX (HRS_WRAP_MAX)
    ) u_hrs_inc (
        .value_i     (hrs_w_q),
        .next_o      (hrs_inc_s),
        .saturated_o (hrs_sat_s)
    );

    // Minutes never exceed 59 here, so its saturation flag stays low.
    bcd_incrementer #(
        .DIGITS   (2),
        .WRAP_EN  (1'b0),
        .WRAP_MAX (8'h00)
    ) u_min_inc (
        .value_i     (min_w_q),
        .next_o      (min_inc_s),
        .saturated_o (min_sat_s)
    );

    // Next-state and datapath: one subtraction per cycle, outputs only move in DONE.
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        hrs_w_d = hrs_w_q;
        min_w_d = min_w_q;
        sec_w_d = sec_w_q;
        ovf_w_d = ovf_w_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        valid_d = valid_q;
        hours_d = hours_q;
        min_d   = min_q;
        sec_d   = sec_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    rem_d   = value;
                    hrs_w_d = '0;
                    min_w_d = 8'h00;
                    sec_w_d = 8'h00;
                    ovf_w_d = 1'b0;
                    busy_d  = 1'b1;
                    state_d = HOURS;
                end else begin
                    state_d = IDLE;
                end
            end
            HOURS: begin
                if (rem_q >= HOUR_N) begin
                    rem_d   = rem_q - HOUR_N;
                    hrs_w_d = hrs_inc_s;
                    ovf_w_d = ovf_w_q | hrs_sat_s;
                end else begin
                    state_d = MINUTES;
                end
            end
            MINUTES: begin
                if (rem_q >= MIN_N) begin
                    rem_d   = rem_q - MIN_N;
                    min_w_d = min_inc_s;
                    ovf_w_d = ovf_w_q | min_sat_s;
                end else begin
                    state_d = TENS;
                end
            end
            TENS: begin
                if (rem_q >= TEN_N) begin
                    rem_d        = rem_q - TEN_N;
                    sec_w_d[7:4] = sec_w_q[7:4] + 4'd1;
                end else begin
                    sec_w_d[3:0] = rem_q[3:0];
                    state_d      = DONE;
                end
            end
            DONE: begin
                hours_d = hrs_w_q;
                min_d   = min_w_q;
                sec_d   = sec_w_q;
                ovf_d   = ovf_w_q;
                done_d  = 1'b1;
                valid_d = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State, working and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rem_q   <= '0;
            hrs_w_q <= '0;
            min_w_q <= 8'h00;
            sec_w_q <= 8'h00;
            ovf_w_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
            hours_q <= '0;
            min_q   <= 8'h00;
            sec_q   <= 8'h00;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            hrs_w_q <= hrs_w_d;
            min_w_q <= min_w_d;
            sec_w_q <= sec_w_d;
            ovf_w_q <= ovf_w_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            valid_q <= valid_d;
            hours_q <= hours_d;
            min_q   <= min_d;
            sec_q   <= sec_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign valid     = valid_q;
    assign hours_bcd = hours_q;
    assign min_bcd   = min_q;
    assign sec_bcd   = sec_q;
    assign overflow  = ovf_q;

endmodule

// File: doc/hms_bcd_formatter.md
Name: hms_bcd_formatter

Overview:
- Downstream consumer of the up/down seconds counter in the digital clock.
- Converts the N-bit binary seconds count into BCD hours/minutes/seconds digits for the display driver.
- Sequential repeated-subtraction converter with start/busy/done handshake.
- Holds the last result stable on its outputs while a new conversion runs.

Parameters:
- N, 19, width of the binary seconds input; matches the counter width.
- HOUR_DIGITS, 3, number of BCD hour digits (3 covers 145 h max at N=19).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- value  in  N  binary seconds count from the counter.
- start  in  1  conversion request; sampled only in IDLE.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  single-cycle pulse when new outputs are written.
- valid  out  1  set by the first done; cleared only by reset.
- hours_bcd  out  4*HOUR_DIGITS  BCD hours, most significant digit first.
- min_bcd  out  8  BCD minutes, 00-59.
- sec_bcd  out  8  BCD seconds, 00-59.
- overflow  out  1  hours saturated in the last conversion.

Behaviour:
- Reset (asynchronous, any state): state=IDLE; busy=0, done=0, valid=0, overflow=0; all BCD outputs 0; working registers 0.
- FSM states: IDLE, HOURS, MINUTES, TENS, DONE.
- IDLE: when start=1, latch rem<=value, clear the working BCD/overflow registers, then go to HOURS. Otherwise stay in IDLE.
- HOURS:
  - If rem>=3600: rem-=3600 and BCD-increment the working hours, one step per cycle.
  - Otherwise go to MINUTES.
- MINUTES: if rem>=60: rem-=60 and BCD-increment the working minutes; otherwise go to TENS.
- TENS:
  - If rem>=10: rem-=10 and increment the seconds tens digit.
  - Otherwise the seconds units digit <= rem[3:0], then go to DONE.
- DONE:
  - Copy working registers to the outputs; pulse done=1 for one cycle; set valid=1.
  - Return to IDLE. busy falls in the same cycle that done is high.
- Latency: the start edge to the done-high cycle is H+M+T+4 cycles (H=hours, M=minutes, T=seconds tens). There are no fixed-latency guarantees beyond this.
- Arithmetic: subtractions use an N-bit rem; compare constants are zero-extended to N bits. The BCD increment carries digit-wise (9→0 with carry).
- start while busy: ignored; no queuing.
- start held high: re-triggers in every IDLE cycle, i.e. a back-to-back conversion every H+M+T+5 cycles.
- Hours saturation: if working hours = all nines and rem>=3600 in HOURS:
  - hours stays all nines; overflow is set; subtraction continues.
  - Minutes and seconds therefore remain correct.
- Counter underflow wrap (value=2^N-1) is converted literally (N=19 → 145:38:07). No special handling.
- Reset mid-conversion aborts immediately. valid=0 until the next completed conversion.

Optional Feature:
- Macro: HMS_MOD24_EN.
- Defined: the hours increment wraps 23→00 (two BCD digits used; upper digits of hours_bcd forced 0). overflow is never set. Output is wall-clock time of day.
- Undefined: hours count up to 10^HOUR_DIGITS-1 with saturation and overflow as described in Behaviour.

Decomposition:
- Shared package clock_pkg:
  - Constants SEC_PER_HOUR=3600 and SEC_PER_MIN=60.
  - Typedef bcd_digit_t (4-bit).
  - FSM state enum hms_state_t (IDLE, HOURS, MINUTES, TENS, DONE).
- Sub-module bcd_incrementer:
  - Parameterised digit count; combinational next-value with carry.
  - Optional wrap limit (for mod-24) and saturate-at-max with a saturated flag.
  - Instantiated for hours and minutes.

Test Plan:
- Reset mid-run: start with value=86399, assert rst_n=0 on cycle 10 → all outputs 0, busy=0, valid=0; next start with value=0 → done after 4 cycles, 000:00:00, valid=1.
- value=3661, pulse start → done on cycle 6, hours_bcd=001, min_bcd=01, sec_bcd=01, overflow=0; outputs unchanged until done.
- value=86399 → done on cycle 91, 023:59:59; a start pulse on cycle 40 is ignored (single done, busy never drops early).
- value=524287 (N=19 wrap) → done on cycle 187, 145:38:07, overflow=0.
- N=22, HOUR_DIGITS=2, value=360000 → hours_bcd=99, min_bcd=00, sec_bcd=00, overflow=1; next conversion of value=59 → 00:00:59, overflow=0.
- With HMS_MOD24_EN, value=90000 → hours_bcd=001, min_bcd=00, sec_bcd=00, overflow=0.
